// File: rtl/gshare_pht.sv
// gshare_pht
// Gshare pattern history table. This block also consumes the global branch
// history register.
//
// Fetch side: the table is indexed by pred_pc[HIST_W+1:2] XOR history. It
// returns the MSB of the addressed 2-bit counter as the prediction. Each
// accepted prediction pushes {index, prediction} into an in-order queue.
//
// Commit side: resolutions arrive in program order. Each one pops the oldest
// queued entry, trains that entry's counter with saturation, and reports a
// registered mispredict one cycle later.
//
// A flush empties the queue but keeps the table contents.
//
// Ports:
//   clk              rising-edge clock
//   reset            synchronous, active-high reset
//   pred_valid       fetch requests a prediction
//   pred_pc          branch PC
//   history          current global history
//   pred_taken       prediction; combinational from the current table
//   pred_ready       queue not full (based on the registered count only)
//   resolve_valid    oldest in-flight branch resolved this cycle
//   resolve_taken    actual branch outcome
//   flush            discard all queued entries
//   mispredict_valid registered; pulses one cycle after an accepted resolve
//   mispredict       registered; stored prediction != actual outcome
//   q_empty          queue holds no entries
module gshare_pht #(
  parameter int HIST_W  = 10,
  parameter int PC_W    = 32,
  parameter int Q_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pred_valid,
  input  logic [PC_W-1:0]   pred_pc,
  input  logic [HIST_W-1:0] history,
  output logic              pred_taken,
  output logic              pred_ready,
  input  logic              resolve_valid,
  input  logic              resolve_taken,
  input  logic              flush,
  output logic              mispredict_valid,
  output logic              mispredict,
  output logic              q_empty
);

  localparam int TBL_N = 1 << HIST_W;
  localparam int PTR_W = $clog2(Q_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Saturating 2-bit counter update. It stops at 2'b11 when counting up
  // and at 2'b00 when counting down.
  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    if (taken) begin
      if (ctr == 2'b11) res = 2'b11;
      else              res = ctr + 2'b01;
    end else begin
      if (ctr == 2'b00) res = 2'b00;
      else              res = ctr - 2'b01;
    end
    return res;
  endfunction

  logic [1:0]        table_q [TBL_N];
  logic [HIST_W-1:0] q_idx_q [Q_DEPTH];
  logic              q_pred_q [Q_DEPTH];

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              mis_valid_q;
  logic              mis_q;

  logic [HIST_W-1:0] tbl_idx_s;
  logic [HIST_W-1:0] head_idx_s;
  logic              head_pred_s;
  logic              push_s;
  logic              pop_s;
  logic              unused_pc_s;

  // The PC bits outside the index field do not take part in the lookup.
  assign unused_pc_s = ^{pred_pc[PC_W-1:HIST_W+2], pred_pc[1:0]};

  assign tbl_idx_s   = pred_pc[HIST_W+1:2] ^ history;
  assign pred_taken  = table_q[tbl_idx_s][1];
  assign pred_ready  = (count_q != CNT_W'(Q_DEPTH));
  assign q_empty     = (count_q == {CNT_W{1'b0}});
  assign head_idx_s  = q_idx_q[head_q];
  assign head_pred_s = q_pred_q[head_q];

  // A flush drops any enqueue in the same cycle. A same-cycle resolve still pops.
  assign push_s = pred_valid && pred_ready && !flush;
  assign pop_s  = resolve_valid && !q_empty;

  assign mispredict_valid = mis_valid_q;
  assign mispredict       = mis_q;

  // Next-state logic for the queue pointers and the occupancy count.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      // The resolve pop is irrelevant here because everything is discarded.
      head_d  = tail_q;
      count_d = {CNT_W{1'b0}};
    end else begin
      if (push_s) tail_d = tail_q + PTR_W'(1);
      else        tail_d = tail_q;
      if (pop_s)  head_d = head_q + PTR_W'(1);
      else        head_d = head_q;
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Queue control state and the registered mispredict report.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q      <= {PTR_W{1'b0}};
      tail_q      <= {PTR_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      mis_valid_q <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      mis_valid_q <= pop_s;
      if (pop_s) mis_q <= head_pred_s ^ resolve_taken;
      else       mis_q <= mis_q;
    end
  end

  // Pattern history table. Reset loads weak not-taken everywhere. Training
  // writes only the popped entry's counter. A prediction to the same index in
  // the same cycle reads the old value; there is no bypass.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TBL_N; i++) table_q[i] <= 2'b01;
    end else if (pop_s) begin
      table_q[head_idx_s] <= sat_update(table_q[head_idx_s], resolve_taken);
    end
  end

  // Queue payload storage. It needs no reset because count/head/tail decide
  // which slots hold live entries.
  always_ff @(posedge clk) begin
    if (push_s) begin
      q_idx_q[tail_q]  <= tbl_idx_s;
      q_pred_q[tail_q] <= pred_taken;
    end
  end

endmodule

// File: tb/tb_gshare_pht.sv
module tb_gshare_pht;

  localparam int HIST_W  = 10;
  localparam int PC_W    = 32;
  localparam int Q_DEPTH = 16;
  localparam int TBL_N   = 1 << HIST_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              pred_valid;
  logic [PC_W-1:0]   pred_pc;
  logic [HIST_W-1:0] history;
  logic              pred_taken;
  logic              pred_ready;
  logic              resolve_valid;
  logic              resolve_taken;
  logic              flush;
  logic              mispredict_valid;
  logic              mispredict;
  logic              q_empty;

  gshare_pht #(.HIST_W(HIST_W), .PC_W(PC_W), .Q_DEPTH(Q_DEPTH)) dut (
    .clk              (clk),
    .reset            (reset),
    .pred_valid       (pred_valid),
    .pred_pc          (pred_pc),
    .history          (history),
    .pred_taken       (pred_taken),
    .pred_ready       (pred_ready),
    .resolve_valid    (resolve_valid),
    .resolve_taken    (resolve_taken),
    .flush            (flush),
    .mispredict_valid (mispredict_valid),
    .mispredict       (mispredict),
    .q_empty          (q_empty)
  );

  always #5 clk = ~clk;

  // Reference model: a plain integer counter per index, plus a queue of
  // outstanding predictions.
  typedef struct { int idx; bit pred; } ent_t;
  int   mtbl [TBL_N];
  ent_t mq [$];
  bit   m_mv;
  bit   m_mp;
  int   n_pass   = 0;
  int   n_checks = 0;

  function automatic int m_idx(input logic [PC_W-1:0] pc, input logic [HIST_W-1:0] h);
    return (int'(pc / 4) % TBL_N) ^ int'(h);
  endfunction

  function automatic bit m_pred(input int idx);
    return mtbl[idx] >= 2;
  endfunction

  function automatic bit m_ready();
    return mq.size() < Q_DEPTH;
  endfunction

  task automatic apply(input bit pv, input logic [PC_W-1:0] pc, input logic [HIST_W-1:0] h,
                       input bit rv, input bit rt, input bit fl);
    pred_valid    = pv;
    pred_pc       = pc;
    history       = h;
    resolve_valid = rv;
    resolve_taken = rt;
    flush         = fl;
    #1;
  endtask

  // Advance the model by one clock using the inputs the bench is driving,
  // then clock the DUT and idle the control inputs.
  task automatic tick();
    int   idx;
    bit   p;
    bit   acc;
    ent_t h;
    if (reset) begin
      foreach (mtbl[i]) mtbl[i] = 1;
      mq.delete();
      m_mv = 1'b0;
      m_mp = 1'b0;
    end else begin
      idx = m_idx(pred_pc, history);
      p   = m_pred(idx);
      acc = pred_valid && m_ready() && !flush;
      if (resolve_valid && mq.size() > 0) begin
        h    = mq.pop_front();
        m_mv = 1'b1;
        m_mp = h.pred ^ resolve_taken;
        if (resolve_taken) mtbl[h.idx] = (mtbl[h.idx] < 3) ? mtbl[h.idx] + 1 : 3;
        else               mtbl[h.idx] = (mtbl[h.idx] > 0) ? mtbl[h.idx] - 1 : 0;
      end else begin
        m_mv = 1'b0;
      end
      if (flush) mq.delete();
      else if (acc) mq.push_back('{idx, p});
    end
    @(posedge clk);
    #1;
    reset         = 1'b0;
    pred_valid    = 1'b0;
    resolve_valid = 1'b0;
    flush         = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    apply(1'b1, 32'h40, 10'h000, 1'b1, 1'b1, 1'b0);
    tick();
    apply(1'b0, 32'h40, 10'h000, 1'b0, 1'b0, 1'b0);
    n_checks++; if (q_empty !== 1'b1) $display("FAIL reset_q_empty: got %b want 1", q_empty); else n_pass++;
    n_checks++; if (pred_ready !== 1'b1) $display("FAIL reset_pred_ready: got %b want 1", pred_ready); else n_pass++;
    n_checks++; if (mispredict_valid !== 1'b0) $display("FAIL reset_mis_valid: got %b want 0", mispredict_valid); else n_pass++;
    n_checks++; if (mispredict !== 1'b0) $display("FAIL reset_mis: got %b want 0", mispredict); else n_pass++;
    n_checks++; if (pred_taken !== 1'b0) $display("FAIL reset_pred_taken: got %b want 0", pred_taken); else n_pass++;
  endtask

  task automatic test_predict();
    apply(1'b1, 32'h40, 10'h000, 1'b0, 1'b0, 1'b0);
    n_checks++; if (pred_taken !== m_pred(m_idx(32'h40, 10'h000))) $display("FAIL pred_first: got %b want %b", pred_taken, m_pred(m_idx(32'h40, 10'h000))); else n_pass++;
    n_checks++; if (q_empty !== 1'b1) $display("FAIL pred_q_empty_before: got %b want 1", q_empty); else n_pass++;
    tick();
    n_checks++; if (q_empty !== 1'b0) $display("FAIL pred_q_empty_after: got %b want 0", q_empty); else n_pass++;
  endtask

  task automatic test_resolve();
    apply(1'b0, 32'h40, 10'h000, 1'b1, 1'b1, 1'b0);
    tick();
    n_checks++; if (mispredict_valid !== 1'b1) $display("FAIL resolve_mis_valid: got %b want 1", mispredict_valid); else n_pass++;
    n_checks++; if (mispredict !== m_mp) $display("FAIL resolve_mis: got %b want %b", mispredict, m_mp); else n_pass++;
    apply(1'b0, 32'h40, 10'h000, 1'b0, 1'b0, 1'b0);
    n_checks++; if (pred_taken !== 1'b1) $display("FAIL resolve_repredict: got %b want 1", pred_taken); else n_pass++;
    n_checks++; if (q_empty !== 1'b1) $display("FAIL resolve_q_empty: got %b want 1", q_empty); else n_pass++;
  endtask

  task automatic test_alias_saturate();
    apply(1'b0, 32'h40, 10'h010, 1'b0, 1'b0, 1'b0);
    n_checks++; if (pred_taken !== 1'b0) $display("FAIL alias_idx0: got %b want 0", pred_taken); else n_pass++;
    for (int k = 0; k < 7; k++) begin
      apply(1'b1, 32'h40, 10'h010, 1'b0, 1'b0, 1'b0);
      tick();
      apply(1'b0, 32'h40, 10'h010, 1'b1, (k < 4) ? 1'b1 : 1'b0, 1'b0);
      tick();
      n_checks++; if (mispredict_valid !== 1'b1 || mispredict !== m_mp) $display("FAIL alias_train%0d: got v=%b m=%b want v=1 m=%b", k, mispredict_valid, mispredict, m_mp); else n_pass++;
      apply(1'b0, 32'h40, 10'h010, 1'b0, 1'b0, 1'b0);
      n_checks++; if (pred_taken !== m_pred(0)) $display("FAIL alias_pred%0d: got %b want %b", k, pred_taken, m_pred(0)); else n_pass++;
    end
    n_checks++; if (pred_taken !== 1'b0) $display("FAIL alias_final: got %b want 0", pred_taken); else n_pass++;
  endtask

  task automatic test_full();
    logic [PC_W-1:0]   pc;
    logic [HIST_W-1:0] h;
    for (int k = 0; k < Q_DEPTH; k++) begin
      pc = $urandom; h = HIST_W'($urandom);
      apply(1'b1, pc, h, 1'b0, 1'b0, 1'b0);
      n_checks++; if (pred_ready !== 1'b1) $display("FAIL full_ready_fill%0d: got %b want 1", k, pred_ready); else n_pass++;
      tick();
    end
    pc = $urandom; h = HIST_W'($urandom);
    apply(1'b1, pc, h, 1'b1, 1'($urandom), 1'b0);
    n_checks++; if (pred_ready !== 1'b0) $display("FAIL full_ready_low: got %b want 0", pred_ready); else n_pass++;
    tick();
    n_checks++; if (pred_ready !== 1'b1) $display("FAIL full_ready_after_pop: got %b want 1", pred_ready); else n_pass++;
    n_checks++; if (mispredict_valid !== 1'b1 || mispredict !== m_mp) $display("FAIL full_pop_report: got v=%b m=%b want v=1 m=%b", mispredict_valid, mispredict, m_mp); else n_pass++;
    while (mq.size() > 0) begin
      apply(1'b0, pc, h, 1'b1, 1'($urandom), 1'b0);
      tick();
      n_checks++; if (mispredict_valid !== 1'b1 || mispredict !== m_mp) $display("FAIL full_drain: got v=%b m=%b want v=1 m=%b", mispredict_valid, mispredict, m_mp); else n_pass++;
    end
    n_checks++; if (q_empty !== 1'b1) $display("FAIL full_drained_empty: got %b want 1", q_empty); else n_pass++;
  endtask

  task automatic test_flush();
    for (int k = 0; k < 5; k++) begin
      apply(1'b1, $urandom, HIST_W'($urandom), 1'b0, 1'b0, 1'b0);
      tick();
    end
    apply(1'b1, $urandom, HIST_W'($urandom), 1'b1, 1'($urandom), 1'b1);
    tick();
    n_checks++; if (mispredict_valid !== 1'b1 || mispredict !== m_mp) $display("FAIL flush_resolve: got v=%b m=%b want v=1 m=%b", mispredict_valid, mispredict, m_mp); else n_pass++;
    n_checks++; if (q_empty !== 1'b1) $display("FAIL flush_q_empty: got %b want 1", q_empty); else n_pass++;
    apply(1'b0, 32'h0, 10'h0, 1'b1, 1'b1, 1'b0);
    tick();
    n_checks++; if (mispredict_valid !== 1'b0) $display("FAIL flush_empty_resolve: got %b want 0", mispredict_valid); else n_pass++;
  endtask

  task automatic test_random();
    logic [PC_W-1:0]   pc;
    logic [HIST_W-1:0] h;
    bit                pv, rv, rt, fl;
    for (int k = 0; k < 600; k++) begin
      // A small index space forces aliasing and same-index predict/resolve.
      pc = PC_W'($urandom_range(0, 7)) << 2;
      h  = HIST_W'($urandom_range(0, 3));
      pv = ($urandom_range(0, 99) < 60);
      rv = ($urandom_range(0, 99) < 45);
      rt = 1'($urandom);
      fl = ($urandom_range(0, 99) < 3);
      apply(pv, pc, h, rv, rt, fl);
      n_checks++; if (pred_taken !== m_pred(m_idx(pc, h))) $display("FAIL rand_pred%0d: got %b want %b", k, pred_taken, m_pred(m_idx(pc, h))); else n_pass++;
      n_checks++; if (pred_ready !== m_ready()) $display("FAIL rand_ready%0d: got %b want %b", k, pred_ready, m_ready()); else n_pass++;
      n_checks++; if (q_empty !== (mq.size() == 0)) $display("FAIL rand_empty%0d: got %b want %b", k, q_empty, mq.size() == 0); else n_pass++;
      tick();
      n_checks++; if (mispredict_valid !== m_mv) $display("FAIL rand_mis_valid%0d: got %b want %b", k, mispredict_valid, m_mv); else n_pass++;
      if (m_mv) begin
        n_checks++; if (mispredict !== m_mp) $display("FAIL rand_mis%0d: got %b want %b", k, mispredict, m_mp); else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 8; k++) begin
      apply(1'b1, $urandom, HIST_W'($urandom), 1'b0, 1'b0, 1'b0);
      tick();
    end
    reset = 1'b1;
    apply(1'b1, $urandom, HIST_W'($urandom), 1'b1, 1'b1, 1'b0);
    tick();
    n_checks++; if (q_empty !== 1'b1) $display("FAIL midreset_q_empty: got %b want 1", q_empty); else n_pass++;
    n_checks++; if (pred_ready !== 1'b1) $display("FAIL midreset_ready: got %b want 1", pred_ready); else n_pass++;
    n_checks++; if (mispredict_valid !== 1'b0) $display("FAIL midreset_mis_valid: got %b want 0", mispredict_valid); else n_pass++;
    for (int i = 0; i < TBL_N; i++) begin
      apply(1'b0, 32'h0, HIST_W'(i), 1'b0, 1'b0, 1'b0);
      n_checks++; if (pred_taken !== 1'b0) $display("FAIL midreset_tbl[%0d]: got %b want 0", i, pred_taken); else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1; pred_valid = 1'b0; pred_pc = '0; history = '0;
    resolve_valid = 1'b0; resolve_taken = 1'b0; flush = 1'b0;
    test_reset();
    test_predict();
    test_resolve();
    test_alias_saturate();
    test_full();
    test_flush();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gshare_pht.md
Name: gshare_pht

Overview:
- Gshare pattern history table and the consumer of the global branch history register.
- Fetch presents a branch PC and the current 10-bit history. The table returns a taken/not-taken prediction and records the index it used in an in-order queue.
- At branch resolution (in program order, from commit), the oldest queued entry is popped. Its 2-bit saturating counter is trained and a mispredict flag is reported.
- A flush discards all in-flight entries.

Parameters:
- HIST_W, 10, global history width; the table has 2^HIST_W entries.
- PC_W, 32, branch PC width.
- Q_DEPTH, 16, in-flight prediction queue depth (power of two).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- pred_valid  input  1  fetch requests a prediction this cycle.
- pred_pc  input  PC_W  branch PC.
- history  input  HIST_W  current global history from the history register.
- pred_taken  output  1  prediction, combinational from the current table contents.
- pred_ready  output  1  queue not full; a prediction is accepted only when pred_valid && pred_ready.
- resolve_valid  input  1  oldest in-flight branch resolved this cycle.
- resolve_taken  input  1  actual outcome.
- flush  input  1  discard all queued entries.
- mispredict_valid  output  1  registered; pulses 1 cycle after an accepted resolve.
- mispredict  output  1  registered; stored prediction != resolve_taken; valid with mispredict_valid.
- q_empty  output  1  queue holds no entries.

Behaviour:
- Index = pred_pc[HIST_W+1:2] XOR history.
- Table: 2^HIST_W 2-bit counters. Encoding: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.
- pred_taken = counter[index][1]. It is always driven, even when pred_valid=0.
- Enqueue: on pred_valid && pred_ready, push {index, pred_taken} at the tail.
- pred_ready = (count != Q_DEPTH). Ready is derived from the registered count only, so a same-cycle resolve does not free a slot.
- Resolve: on resolve_valid && !q_empty, pop the head.
  - counter[head.index] increments if taken, decrements if not taken.
  - Saturates at 11 and 00.
  - Next cycle: mispredict_valid=1 and mispredict = head.pred ^ resolve_taken.
- Resolve while empty: ignored. No table write; mispredict_valid=0 next cycle.
- Same-cycle predict and resolve to the same index: the prediction reads the pre-update counter. There is no bypass.
- Simultaneous enqueue and pop: count is unchanged; both pointers advance.
- Flush:
  - Resolve in the same cycle is processed first (table trained, mispredict reported).
  - The queue is then cleared: head=tail, count=0.
  - Any enqueue that cycle is dropped.
  - Table contents are kept.
- Pointer wrap: head and tail are log2(Q_DEPTH) bits and wrap modulo Q_DEPTH. count is log2(Q_DEPTH)+1 bits.
- Reset, including mid-operation:
  - All counters = 01; queue empty (count=0, pointers 0).
  - mispredict_valid=0, mispredict=0.
  - Resulting outputs: pred_ready=1, q_empty=1, pred_taken=0.
- Latency: prediction 0 cycles (combinational); mispredict report 1 cycle; table update visible to predictions on the next cycle.

Test Plan:
1. Reset, then pred_pc=0x40, history=0x000 (index 0x010) -> pred_taken=0, pred_ready=1, q_empty=1 before the request and q_empty=0 after it.
2. Resolve the scenario-1 entry with resolve_taken=1 -> next cycle mispredict_valid=1, mispredict=1; counter[0x010]=10; re-predict pc=0x40, history=0 -> pred_taken=1.
3. Index aliasing: pc=0x40, history=0x010 -> index 0x000, unaffected by scenario 2 (pred_taken=0). Train index 0x000 taken four times -> saturates at 11; then three not-taken resolves -> 00, pred_taken=0.
4. Full queue: 16 accepted predictions -> pred_ready=0; a 17th pred_valid is not enqueued. A resolve in that cycle pops one -> pred_ready=1 the following cycle.
5. Flush with 5 entries queued plus a same-cycle resolve and pred_valid -> oldest entry trained and reported; q_empty=1 next cycle; dropped prediction never resolves; resolve_valid on empty -> mispredict_valid stays 0.
6. Reset asserted with 8 entries queued and trained counters -> next cycle q_empty=1, pred_ready=1, mispredict_valid=0, and every index predicts not-taken (counter 01).
